mandelbrot_pixel_engine: RTL and testbench
==========================================

Name: mandelbrot_pixel_engine

Overview:
Per-pixel escape-time iteration core that feeds the Mandelbrot drawing stage. It accepts one complex point c plus a pixel byte-address tag, iterates z := z^2 + c in signed fixed point at one iteration per clock, and returns the iteration count and an 8-bit colour. The drawing stage consumes the result and issues the framebuffer write (word address = tag[19:2], nbyte from tag[1:0]).

Parameters:
DATA_W, 16, width of signed fixed-point coordinates (Q4.12 at defaults)
FRAC_BITS, 12, fractional bits of coordinates
CNT_W, 16, width of iteration counter and max_iter
TAG_W, 20, width of pass-through pixel byte-address tag

Ports:
clk  in  1  master clock
reset  in  1  asynchronous, active-high reset
max_iter  in  CNT_W  iteration limit; sampled on accept
in_valid  in  1  point request valid
in_ready  out  1  engine can accept a point (high only in IDLE)
c_re  in  DATA_W  real part of c, signed Q4.12
c_im  in  DATA_W  imaginary part of c, signed Q4.12
in_tag  in  TAG_W  pixel byte address, passed through unchanged
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_count  out  CNT_W  iterations completed before escape, or max_iter if not escaped
out_colour  out  8  pixel value
out_tag  out  TAG_W  tag captured on accept
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE; in_ready=1 after reset release; out_valid=0, busy=0, out_count=0, out_colour=0, out_tag=0, z and n cleared.
- States: IDLE, ITER, DONE.
- IDLE: in_ready=1. Accept on in_valid && in_ready at clock edge: latch c_re, c_im, in_tag, max_iter; z_re=z_im=0, n=0; go ITER.
- ITER, each cycle: zr2=z_re*z_re, zi2=z_im*z_im, zri=z_re*z_im (2*DATA_W signed products); mag=zr2+zi2 at 2*DATA_W+1 bits.
  - escape if mag >= 4.0 (4 << 2*FRAC_BITS); or limit if n == max_iter -> out_count=n, go DONE.
  - else z_re = ((zr2 - zi2) >>> FRAC_BITS) + c_re; z_im = ((2*zri) >>> FRAC_BITS) + c_im (truncate to DATA_W); n = n+1.
  - Escape takes priority over limit when both are true; out_count is n in either case.
- No overflow handling is required for |c_re|,|c_im| < 4.0. Larger c is out of contract.
- DONE: out_valid=1; outputs hold stable until out_valid && out_ready at an edge, then go IDLE. in_ready=0.
- Colour: if out_count == max_iter (inside), colour 8'h00. Otherwise colour is out_count[7:0], with 8'h00 mapped to 8'h01.
- Latency: out_valid rises count+2 edges after the accept edge. Throughput is one point at a time, with no overlap.
- max_iter=0: first ITER cycle terminates, count=0, colour 8'h00.
- Inputs are ignored outside IDLE. Reset mid-operation aborts immediately to the reset state; the result is discarded.

Optional Feature:
MANDEL_BULB_CHECK_EN
- Defined: in the first ITER cycle (n==0), compute (c_re+1.0)^2 + c_im^2. If < 1/16 (period-2 bulb), go DONE with count=max_iter; result_valid is 2 edges after accept.
- Undefined: no check; points iterate normally. Results are identical except for latency.

Decomposition:
- Package mandelbrot_pkg holds:
  - DATA_W, FRAC_BITS, CNT_W, TAG_W defaults
  - ESCAPE_SQ constant (4.0 scaled)
  - BULB_RADIUS_SQ constant (1/16 scaled)
  - ONE constant (16'h1000)
  - state encoding enum: IDLE/ITER/DONE
- One sub-module, mandelbrot_iter_step: purely combinational datapath for the ITER cycle. Computes squares, next z, escape flag and optional bulb flag. The top holds the FSM, registers and handshake.

Test Plan:
- Reset mid-ITER (c=0, max_iter=100, reset at cycle 10) -> out_valid=0, busy=0, in_ready=1 immediately; next request runs correctly.
- c=(16'h1000,0), max_iter=50, tag=20'h00123 -> count=2, colour=8'h02, out_tag=20'h00123, out_valid 4 edges after accept.
- c=(0,0), max_iter=20 -> count=20, colour=8'h00, out_valid 22 edges after accept.
- c=(16'h2000,0), max_iter=10, out_ready held low 5 cycles -> count=1, colour=8'h01; outputs stable while stalled; in_ready=0 until handshake completes.
- max_iter=0, c=(16'h1000,16'h1000) -> count=0, colour=8'h00, latency 2.
- c=(16'hF000,0), max_iter=200 -> count=200, colour=8'h00; latency 2 with MANDEL_BULB_CHECK_EN, 202 without.

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared definitions for the Mandelbrot pixel engine: default widths,
// fixed-point constants at the default Q4.12 format, the FSM state type and
// the colour mapping helper.
// Build option: MANDEL_BULB_CHECK_EN enables the period-2 bulb early exit.
package mandelbrot_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 12;
  localparam int CNT_W     = 16;
  localparam int TAG_W     = 20;

  // |z|^2 escape threshold: 4.0 with 2*FRAC_BITS fractional bits.
  localparam logic [2*DATA_W:0] ESCAPE_SQ = (2*DATA_W+1)'(1) << (2*FRAC_BITS + 2);

  // Period-2 bulb radius squared: 1/16 with 2*FRAC_BITS fractional bits.
  localparam logic [2*DATA_W+2:0] BULB_RADIUS_SQ = (2*DATA_W+3)'(1) << (2*FRAC_BITS - 4);

  // 1.0 in the coordinate format.
  localparam logic [DATA_W-1:0] ONE = 16'h1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Points that never escaped are black; escaped points use the low count
  // byte, with 0 lifted to 1 so an escaped pixel is never black.
  function automatic logic [7:0] colour_map(input logic is_inside, input logic [7:0] count_lo);
    if (is_inside)             return 8'h00;
    else if (count_lo == 8'h00) return 8'h01;
    else                       return count_lo;
  endfunction

endpackage

// File: rtl/mandelbrot_pixel_engine_iter_step.sv
// Combinational datapath for one escape-time iteration: squares of z, the
// escape test, the next z, and (with MANDEL_BULB_CHECK_EN) the period-2
// bulb membership test on c.
module mandelbrot_iter_step
  import mandelbrot_pkg::*;
#(
  parameter int DATA_W    = mandelbrot_pkg::DATA_W,
  parameter int FRAC_BITS = mandelbrot_pkg::FRAC_BITS
) (
  input  logic signed [DATA_W-1:0] z_re,
  input  logic signed [DATA_W-1:0] z_im,
  input  logic signed [DATA_W-1:0] c_re,
  input  logic signed [DATA_W-1:0] c_im,
  output logic signed [DATA_W-1:0] z_re_next,
  output logic signed [DATA_W-1:0] z_im_next,
  output logic                     escape,
  output logic                     in_bulb
);

  localparam int MAG_W = 2*DATA_W + 1;

  // Package constants are scaled for the default format; any other format
  // derives its thresholds from FRAC_BITS directly.
  localparam bit PKG_FORMAT = (DATA_W == mandelbrot_pkg::DATA_W) &&
                              (FRAC_BITS == mandelbrot_pkg::FRAC_BITS);

  localparam logic [MAG_W-1:0] ESC_LIM =
    PKG_FORMAT ? ESCAPE_SQ : (MAG_W'(1) << (2*FRAC_BITS + 2));

  logic signed [2*DATA_W-1:0] zr2;
  logic signed [2*DATA_W-1:0] zi2;
  logic signed [2*DATA_W-1:0] zri;
  logic        [MAG_W-1:0]    mag;
  logic signed [MAG_W-1:0]    re_diff;
  logic signed [MAG_W-1:0]    im_dbl;
  logic        [DATA_W-1:0]   re_trunc;
  logic        [DATA_W-1:0]   im_trunc;

  assign zr2 = z_re * z_re;
  assign zi2 = z_im * z_im;
  assign zri = z_re * z_im;

  // Both squares are non-negative, so zero extension is exact.
  assign mag    = {1'b0, zr2} + {1'b0, zi2};
  assign escape = (mag >= ESC_LIM);

  assign re_diff = {zr2[2*DATA_W-1], zr2} - {zi2[2*DATA_W-1], zi2};
  assign im_dbl  = {zri, 1'b0};

  // Rescale to the coordinate format, then wrap to DATA_W; c is bounded so
  // the wrap never matters inside the escape radius.
  assign re_trunc = DATA_W'(re_diff >>> FRAC_BITS);
  assign im_trunc = DATA_W'(im_dbl >>> FRAC_BITS);

  assign z_re_next = re_trunc + c_re;
  assign z_im_next = im_trunc + c_im;

`ifdef MANDEL_BULB_CHECK_EN
  localparam logic [DATA_W-1:0] ONE_Q =
    PKG_FORMAT ? ONE : (DATA_W'(1) << FRAC_BITS);
  localparam logic [2*DATA_W+2:0] BULB_LIM =
    PKG_FORMAT ? BULB_RADIUS_SQ : ((2*DATA_W+3)'(1) << (2*FRAC_BITS - 4));

  logic signed [DATA_W:0]     cr1;
  logic signed [2*DATA_W+1:0] cr1_sq;
  logic signed [2*DATA_W-1:0] ci_sq;
  logic        [2*DATA_W+2:0] bulb_mag;

  // (c_re + 1)^2 + c_im^2 < 1/16 marks the period-2 bulb around -1.
  assign cr1      = {c_re[DATA_W-1], c_re} + {1'b0, ONE_Q};
  assign cr1_sq   = cr1 * cr1;
  assign ci_sq    = c_im * c_im;
  assign bulb_mag = {1'b0, cr1_sq} + {3'b000, ci_sq};
  assign in_bulb  = (bulb_mag < BULB_LIM);
`else
  assign in_bulb = 1'b0;
`endif

endmodule

// File: rtl/mandelbrot_pixel_engine.sv
// Escape-time iteration core: accepts one point c with a pixel tag, iterates
// z := z^2 + c once per clock and returns the iteration count and colour.
// One result is produced per accepted point; the next point is taken only
// after the result handshake.
// Build option: MANDEL_BULB_CHECK_EN enables the period-2 bulb early exit.
module mandelbrot_pixel_engine
  import mandelbrot_pkg::*;
#(
  parameter int DATA_W    = mandelbrot_pkg::DATA_W,
  parameter int FRAC_BITS = mandelbrot_pkg::FRAC_BITS,
  parameter int CNT_W     = mandelbrot_pkg::CNT_W,
  parameter int TAG_W     = mandelbrot_pkg::TAG_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CNT_W-1:0]         max_iter,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] c_re,
  input  logic signed [DATA_W-1:0] c_im,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CNT_W-1:0]         out_count,
  output logic [7:0]               out_colour,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     busy
);

  state_e                   state;
  logic signed [DATA_W-1:0] c_re_q;
  logic signed [DATA_W-1:0] c_im_q;
  logic signed [DATA_W-1:0] z_re;
  logic signed [DATA_W-1:0] z_im;
  logic signed [DATA_W-1:0] z_re_next;
  logic signed [DATA_W-1:0] z_im_next;
  logic [CNT_W-1:0]         n;
  logic [CNT_W-1:0]         max_q;
  logic [TAG_W-1:0]         tag_q;
  logic                     escape;
  logic                     in_bulb;
  logic                     bulb_hit;
  logic                     at_limit;

  mandelbrot_iter_step #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_step (
    .z_re      (z_re),
    .z_im      (z_im),
    .c_re      (c_re_q),
    .c_im      (c_im_q),
    .z_re_next (z_re_next),
    .z_im_next (z_im_next),
    .escape    (escape),
    .in_bulb   (in_bulb)
  );

  // The bulb test depends only on c, so it is consulted on the first pass.
  assign bulb_hit = in_bulb && (n == '0);
  assign at_limit = (n == max_q);

  // Handshake FSM, iteration registers and registered result outputs.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later lines see new z/n.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      out_valid  <= 1'b0;
      out_count  <= '0;
      out_colour <= '0;
      out_tag    <= '0;
      z_re       <= '0;
      z_im       <= '0;
      n          <= '0;
      c_re_q     <= '0;
      c_im_q     <= '0;
      tag_q      <= '0;
      max_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            c_re_q   <= c_re;
            c_im_q   <= c_im;
            tag_q    <= in_tag;
            max_q    <= max_iter;
            z_re     <= '0;
            z_im     <= '0;
            n        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ITER;
          end
        end

        ITER: begin
          if (escape || at_limit || bulb_hit) begin
            // Escape wins; a bulb point is reported as never escaping.
            out_count <= (bulb_hit && !escape) ? max_q : n;
            out_tag   <= tag_q;
            state     <= DONE;
          end else begin
            z_re <= z_re_next;
            z_im <= z_im_next;
            n    <= n + 1'b1;
          end
        end

        DONE: begin
          if (!out_valid) begin
            // First DONE cycle maps the settled count to a colour.
            out_colour <= colour_map(out_count == max_q, out_count[7:0]);
            out_valid  <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_pixel_engine.sv
// Self-checking bench for mandelbrot_pixel_engine: directed cases with known
// results, a mid-iteration reset, and randomized points compared against an
// arithmetic reference of the escape-time rules.
module tb_mandelbrot_pixel_engine;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 12;
  localparam int CNT_W     = 16;
  localparam int TAG_W     = 20;

  logic                     clk;
  logic                     reset;
  logic [CNT_W-1:0]         max_iter;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] c_re;
  logic signed [DATA_W-1:0] c_im;
  logic [TAG_W-1:0]         in_tag;
  logic                     out_valid;
  logic                     out_ready;
  logic [CNT_W-1:0]         out_count;
  logic [7:0]               out_colour;
  logic [TAG_W-1:0]         out_tag;
  logic                     busy;

  int passed = 0;
  int total  = 0;

  mandelbrot_pixel_engine #(
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .CNT_W     (CNT_W),
    .TAG_W     (TAG_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .max_iter   (max_iter),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .c_re       (c_re),
    .c_im       (c_im),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_count  (out_count),
    .out_colour (out_colour),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: wrap a value to a signed 16-bit coordinate.
  function automatic longint wrap16(input longint v);
    logic signed [15:0] t;
    t = v[15:0];
    return longint'(t);
  endfunction

  // Reference: escape-time count, colour and latency straight from the rules.
  function automatic void ref_point(input int cr, input int ci, input int maxi,
                                    output int cnt, output int col, output int lat);
    longint zr, zi, nzr, nzi, a;
    int n;
    bit bulb;
    zr = 0; zi = 0; n = 0; bulb = 0;
    a  = longint'(cr) + 4096;
`ifdef MANDEL_BULB_CHECK_EN
    if (a*a + longint'(ci)*longint'(ci) < (longint'(1) << 20)) bulb = 1;
`else
    if (a < -100000) bulb = 0;
`endif
    if (bulb) begin
      cnt = maxi;
      lat = 2;
    end else begin
      while ((zr*zr + zi*zi) < (longint'(4) << 24) && n != maxi) begin
        nzr = wrap16(((zr*zr - zi*zi) >>> 12) + longint'(cr));
        nzi = wrap16(((2*zr*zi) >>> 12) + longint'(ci));
        zr = nzr;
        zi = nzi;
        n++;
      end
      cnt = n;
      lat = n + 2;
    end
    if (cnt == maxi)          col = 0;
    else if (cnt % 256 == 0)  col = 1;
    else                      col = cnt % 256;
  endfunction

  // Drive one point, hold garbage on the inputs while busy, stall the
  // result for 'stall' cycles, then complete the handshake.
  task automatic do_point(input string name, input int cr, input int ci, input int maxi,
                          input int tag, input int stall,
                          input int exp_cnt, input int exp_col, input int exp_lat);
    int edges;
    logic [CNT_W-1:0] h_cnt;
    logic [7:0]       h_col;
    logic [TAG_W-1:0] h_tag;
    edges = 0;
    while (!in_ready && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
    c_re     = 16'(cr);
    c_im     = 16'(ci);
    max_iter = 16'(maxi);
    in_tag   = 20'(tag);
    in_valid = 1'b1;
    @(posedge clk); #1;
    c_re     = 16'($urandom);
    c_im     = 16'($urandom);
    in_tag   = 20'($urandom);
    max_iter = 16'($urandom_range(0, 3));
    edges    = 0;
    while (!out_valid && edges < exp_lat + 20) begin
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;

    total++;
    if (!out_valid || edges != exp_lat) $display("FAIL %s latency: got %0d edges (valid=%0b), expected %0d", name, edges, out_valid, exp_lat);
    else passed++;
    total++;
    if (out_count !== 16'(exp_cnt)) $display("FAIL %s count: got %0d, expected %0d", name, out_count, exp_cnt);
    else passed++;
    total++;
    if (out_colour !== 8'(exp_col)) $display("FAIL %s colour: got %02h, expected %02h", name, out_colour, 8'(exp_col));
    else passed++;
    total++;
    if (out_tag !== 20'(tag)) $display("FAIL %s tag: got %05h, expected %05h", name, out_tag, 20'(tag));
    else passed++;
    total++;
    if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL %s done flags: in_ready=%0b busy=%0b, expected 0/1", name, in_ready, busy);
    else passed++;

    h_cnt = out_count;
    h_col = out_colour;
    h_tag = out_tag;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_count !== h_cnt ||
          out_colour !== h_col || out_tag !== h_tag)
        $display("FAIL %s stall%0d: valid=%0b ready=%0b cnt=%0d col=%02h, expected 1/0/%0d/%02h",
                 name, s, out_valid, in_ready, out_count, out_colour, h_cnt, h_col);
      else passed++;
    end

    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s handshake: valid=%0b in_ready=%0b busy=%0b, expected 0/1/0", name, out_valid, in_ready, busy);
    else passed++;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    c_re      = '0;
    c_im      = '0;
    in_tag    = '0;
    max_iter  = '0;
    #12;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset flags: valid=%0b busy=%0b in_ready=%0b, expected 0/0/1", out_valid, busy, in_ready);
    else passed++;
    total++;
    if (out_count !== '0 || out_colour !== '0 || out_tag !== '0)
      $display("FAIL reset data: cnt=%0d col=%02h tag=%05h, expected 0/00/00000", out_count, out_colour, out_tag);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset release: in_ready=%0b busy=%0b, expected 1/0", in_ready, busy);
    else passed++;
  endtask

  task automatic test_reset_mid_iter();
    c_re     = '0;
    c_im     = '0;
    max_iter = 16'd100;
    in_tag   = 20'h0ABCD;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL mid_iter running: busy=%0b valid=%0b, expected 1/0", busy, out_valid);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mid_iter reset: valid=%0b busy=%0b in_ready=%0b, expected 0/0/1", out_valid, busy, in_ready);
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0;
    do_point("after_reset", 32'h1000, 0, 50, 32'h00777, 0, 2, 2, 4);
  endtask

  task automatic test_directed();
    int lat_bulb;
`ifdef MANDEL_BULB_CHECK_EN
    lat_bulb = 2;
`else
    lat_bulb = 202;
`endif
    do_point("c_one",    32'h1000, 0,        50,  32'h00123, 0, 2,   8'h02, 4);
    do_point("c_zero",   0,        0,        20,  32'h00456, 0, 20,  8'h00, 22);
    do_point("c_two",    32'h2000, 0,        10,  32'h0F00D, 5, 1,   8'h01, 3);
    do_point("max_zero", 32'h1000, 32'h1000, 0,   32'hFFFFF, 0, 0,   8'h00, 2);
    do_point("c_neg1",   -4096,    0,        200, 32'h12345, 1, 200, 8'h00, lat_bulb);
  endtask

  task automatic test_random_back_to_back();
    int cr, ci, maxi, cnt, col, lat, tag, stall;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        cr = int'($urandom_range(0, 32766)) - 16383;
        ci = int'($urandom_range(0, 32766)) - 16383;
      end else begin
        cr = int'($urandom_range(0, 10240)) - 8192;
        ci = int'($urandom_range(0, 10240)) - 5120;
      end
      maxi  = int'($urandom_range(0, 40));
      tag   = int'($urandom_range(0, 20'hFFFFF));
      stall = int'($urandom_range(0, 2));
      ref_point(cr, ci, maxi, cnt, col, lat);
      do_point($sformatf("rand%0d", i), cr, ci, maxi, tag, stall, cnt, col, lat);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_iter();
    test_directed();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
